byte_to_word16_packer: RTL
==========================

Name: byte_to_word16_packer

Overview:
- Sits directly downstream of the bridge byte serialiser in the loader path.
- Consumes its stream of single-byte writes (address, data, strobe) and merges adjacent bytes into 16-bit little-endian words with byte enables.
- Buffers the words in a small FIFO and presents them to a 16-bit memory controller over a valid/ready handshake.
- Lets the bridge path run at full byte rate while the memory side stalls.

Parameters:
- ADDR_WIDTH, 32, width of the incoming byte address; word address is ADDR_WIDTH-1 bits.
- FIFO_DEPTH, 8, word FIFO entries; power of two, >= 2.
- FLUSH_CYCLES, 4, idle cycles with a half-filled word before it is pushed as a partial write; >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_address  in  ADDR_WIDTH  byte address of incoming write.
- mem_data  in  8  byte data.
- mem_wr  in  1  byte write strobe, one byte per cycle; no backpressure upstream.
- flush  in  1  pulse: push any pending half-word as soon as legal.
- word_addr  out  ADDR_WIDTH-1  word address = byte address[ADDR_WIDTH-1:1].
- word_data  out  16  bits [7:0] = even byte, [15:8] = odd byte.
- word_be  out  2  byte enables; bit0 = even lane, bit1 = odd lane.
- word_valid  out  1  FIFO head valid.
- word_ready  in  1  consumer accepts head when word_valid & word_ready.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- idle  out  1  no pending half-word, FIFO empty, no flush outstanding.

Behaviour:
- Reset (async, reset_n low) forces:
  - state IDLE, FIFO empty, timer 0, flush latch 0.
  - word_valid 0, word_addr/word_data/word_be 0.
  - overflow 0, idle 1.
- Pending register: holds one word address, 16-bit data, 2-bit be. Lane = mem_address[0].
- State IDLE, mem_wr=1: load pending with the byte in its lane (other be bit 0), go HOLD, timer 0.
- State HOLD, mem_wr=1, handled by address match and lane:
  - same word, opposite lane: merge; push {addr, data, be=2'b11}; go IDLE.
  - same word, same lane: overwrite that lane (later byte wins); stay HOLD; timer 0.
  - different word: push the old pending word; new byte becomes pending; stay HOLD; timer 0.
- State HOLD, mem_wr=0: timer increments.
  - When timer == FLUSH_CYCLES-1, or the flush latch is set, push pending (partial be) and go IDLE.
- Flush:
  - A flush pulse sets the flush latch; the latch clears on entry to IDLE.
  - With mem_wr in the same cycle, the byte is processed first. If the result is still HOLD, pending is pushed on the next cycle.
  - Flush in IDLE has no effect.
- At most one FIFO push per cycle; at most one pop per cycle.
- Latency: push at rising edge N → word_valid=1 from N+1 when the FIFO was empty. Word output fields come from registered FIFO head.
- Handshake:
  - word_valid, once high, stays high with stable fields until accepted.
  - word_ready is ignored while word_valid=0.
- FIFO full:
  - Push with no pop in the same cycle: word dropped, overflow set to 1, held until reset.
  - Push with simultaneous pop: both succeed; count unchanged.
- Pointers: log2(FIFO_DEPTH)-bit, wrap modulo depth. Full/empty via an extra count bit.
- Reset mid-operation discards pending and FIFO contents immediately.

Test Plan:
- Bytes AA@0x100, BB@0x101, CC@0x102, DD@0x103 on consecutive cycles, word_ready=1 → words (0x80, 0xBBAA, 11) then (0x81, 0xDDCC, 11); each word_valid 1 cycle after its completing byte; idle returns to 1.
- Single byte 0x5A@0x201, then quiet, FLUSH_CYCLES=4 → after 4 quiet cycles one word (0x100, 0x5A00, be=10).
- Byte 0x11@0x300, then flush pulse with no further bytes → next push is (0x180, 0x0011, be=01); 0x12@0x300 then 0x34@0x300 then quiet → data 0x0034 (last byte wins).
- Bytes 0x01@0x10, 0x02@0x20 (different words) → first word (0x08, 0x0001, 01) pushed on the 0x20 cycle; second (0x10, 0x0002, 01) pushed after timeout.
- word_ready=0, stream 2*FIFO_DEPTH+2 paired bytes → first 8 words held stable in order, overflow=1 after the 9th completed word; release ready → exactly 8 words drain.
- Assert reset_n=0 while HOLD with FIFO holding 3 words → same instant word_valid=0, idle=1, overflow=0; no stale words after release.

Source files
------------

// File: rtl/byte_to_word16_packer_if.sv
// Bundles the byte-write input stream and the 16-bit word output handshake.
// Latency: none, wiring only.
// Backpressure: word_ready flows to the packer; the byte side has no ready signal.
interface byte_to_word16_packer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [7:0]            mem_data;
    logic                  mem_wr;
    logic                  flush;
    logic [ADDR_WIDTH-2:0] word_addr;
    logic [15:0]           word_data;
    logic [1:0]            word_be;
    logic                  word_valid;
    logic                  word_ready;
    logic                  overflow;
    logic                  idle;

    // Byte producer and word consumer side.
    modport master (
        output mem_address, mem_data, mem_wr, flush, word_ready,
        input  word_addr, word_data, word_be, word_valid, overflow, idle
    );

    // Packer side.
    modport slave (
        input  mem_address, mem_data, mem_wr, flush, word_ready,
        output word_addr, word_data, word_be, word_valid, overflow, idle
    );
endinterface

// File: rtl/byte_to_word16_packer.sv
// Merges single-byte writes into 16-bit little-endian words with byte enables, queued in a word FIFO.
// Latency: word_valid rises the cycle after the completing byte (or timeout/flush) is pushed into an empty FIFO.
// Backpressure: byte side never stalls; when the FIFO is full and not popping, the new word is dropped and overflow sticks.
module byte_to_word16_packer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    byte_to_word16_packer_if.slave    bus
);
    localparam int WAW = ADDR_WIDTH - 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int PW1 = PW + 1;
    localparam int TW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(FLUSH_CYCLES - 1);
    localparam logic [PW1-1:0] COUNT_FULL = PW1'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [WAW-1:0]  r_pend_addr, w_pend_addr_nxt;
    logic [15:0]     r_pend_data, w_pend_data_nxt;
    logic [1:0]      r_pend_be, w_pend_be_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic            r_flush_latch, w_flush_latch_nxt;

    logic            w_push;
    logic [WAW-1:0]  w_push_addr;
    logic [15:0]     w_push_data;
    logic [1:0]      w_push_be;

    // Incoming byte placed in its lane of a word.
    logic            w_lane;
    logic [WAW-1:0]  w_in_waddr;
    logic [15:0]     w_in_data;
    logic [1:0]      w_in_be;

    assign w_lane     = bus.mem_address[0];
    assign w_in_waddr = bus.mem_address[ADDR_WIDTH-1:1];
    assign w_in_data  = w_lane ? {bus.mem_data, 8'h00} : {8'h00, bus.mem_data};
    assign w_in_be    = w_lane ? 2'b10 : 2'b01;

    // FIFO storage and pointers.
    logic [WAW-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [15:0]     r_fifo_data [FIFO_DEPTH];
    logic [1:0]      r_fifo_be   [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PW1-1:0]  r_count;
    logic            r_overflow;

    logic            w_full, w_valid, w_pop, w_wr_en, w_drop;

    assign w_full  = (r_count == COUNT_FULL);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.word_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // Pending-word state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_pend_addr   <= '0;
            r_pend_data   <= '0;
            r_pend_be     <= '0;
            r_timer       <= '0;
            r_flush_latch <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend_addr   <= w_pend_addr_nxt;
            r_pend_data   <= w_pend_data_nxt;
            r_pend_be     <= w_pend_be_nxt;
            r_timer       <= w_timer_nxt;
            r_flush_latch <= w_flush_latch_nxt;
        end
    end

    // Merge decision: next pending word and the word (if any) pushed this cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_addr_nxt = r_pend_addr;
        w_pend_data_nxt = r_pend_data;
        w_pend_be_nxt   = r_pend_be;
        w_timer_nxt     = r_timer;
        w_push          = 1'b0;
        w_push_addr     = r_pend_addr;
        w_push_data     = r_pend_data;
        w_push_be       = r_pend_be;

        case (r_state)
            ST_IDLE: begin
                if (bus.mem_wr) begin
                    w_pend_addr_nxt = w_in_waddr;
                    w_pend_data_nxt = w_in_data;
                    w_pend_be_nxt   = w_in_be;
                    w_timer_nxt     = '0;
                    w_state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.mem_wr) begin
                    w_timer_nxt = '0;
                    if (w_in_waddr == r_pend_addr) begin
                        if ((r_pend_be & w_in_be) == 2'b00) begin
                            // Opposite lane completes the word.
                            w_push      = 1'b1;
                            w_push_data = r_pend_data | w_in_data;
                            w_push_be   = 2'b11;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            // Pending holds one lane only, so the later byte simply replaces it.
                            w_pend_data_nxt = w_in_data;
                        end
                    end else begin
                        w_push          = 1'b1;
                        w_pend_addr_nxt = w_in_waddr;
                        w_pend_data_nxt = w_in_data;
                        w_pend_be_nxt   = w_in_be;
                    end
                end else if (r_flush_latch || (r_timer == TIMER_LAST)) begin
                    w_push      = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Latch clears on entering IDLE, which also makes a flush in IDLE a no-op.
        if (w_state_nxt == ST_IDLE) begin
            w_flush_latch_nxt = 1'b0;
        end else begin
            w_flush_latch_nxt = r_flush_latch | bus.flush;
        end
    end

    // Word FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
                r_fifo_be[i]   <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_fifo_addr[r_wr_ptr] <= w_push_addr;
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_be[r_wr_ptr]   <= w_push_be;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + PW1'(1);
            end else if (!w_wr_en && w_pop) begin
                r_count <= r_count - PW1'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.word_addr  = r_fifo_addr[r_rd_ptr];
    assign bus.word_data  = r_fifo_data[r_rd_ptr];
    assign bus.word_be    = r_fifo_be[r_rd_ptr];
    assign bus.word_valid = w_valid;
    assign bus.overflow   = r_overflow;
    assign bus.idle       = (r_state == ST_IDLE) && !w_valid && !r_flush_latch;

endmodule
